torus_nic: RTL and testbench

Per-node network interface between a processing core and its torus_switch local port.
- Transmit side: buffers core messages in an injection FIFO and drives the switch's inject port (i_v/i_x/i_y/i_data). It holds each message until the switch returns i_ack.
- Receive side: captures messages the switch delivers with o_v and presents them to the core.
- Also provides self-addressed loopback, traffic counters, a sticky error flag and an idle indication for network-wide termination detection.

---
 rtl/torus_pkg.sv | 27 ++
 rtl/nic_fifo.sv | 47 ++++
 rtl/torus_nic.sv | 109 ++++++++++
 tb/tb_torus_nic.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/torus_pkg.sv
// rtl/torus_pkg.sv - shared message type and address helpers for the torus NIC
package torus_pkg;

  localparam int TP_X_W = 2;
  localparam int TP_Y_W = 2;
  localparam int TP_D_W = 32;
  localparam int MSG_W  = TP_X_W + TP_Y_W + TP_D_W;

  typedef struct packed {
    logic [TP_X_W-1:0] x;
    logic [TP_Y_W-1:0] y;
    logic [TP_D_W-1:0] data;
  } msg_t;

  function automatic logic in_range(input logic [TP_X_W-1:0] x,
                                    input logic [TP_Y_W-1:0] y,
                                    input int nx, input int ny);
    return (int'(x) < nx) && (int'(y) < ny);
  endfunction

  function automatic logic is_self(input logic [TP_X_W-1:0] x,
                                   input logic [TP_Y_W-1:0] y,
                                   input int mx, input int my);
    return (int'(x) == mx) && (int'(y) == my);
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// rtl/nic_fifo.sv - synchronous circular-buffer FIFO with wrap-bit pointers
module nic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Head reads zero when empty so downstream fields never show stale data.
  assign head  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/torus_nic.sv
// rtl/torus_nic.sv - core-to-switch network interface with loopback, counters and idle
module torus_nic
  import torus_pkg::*;
#(
  parameter int X_W   = TP_X_W,
  parameter int Y_W   = TP_Y_W,
  parameter int D_W   = TP_D_W,
  parameter int X     = 2,
  parameter int Y     = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tx_v,
  input  logic [X_W-1:0] tx_x,
  input  logic [Y_W-1:0] tx_y,
  input  logic [D_W-1:0] tx_data,
  output logic           tx_rdy,
  output logic           sw_i_v,
  output logic [X_W-1:0] sw_i_x,
  output logic [Y_W-1:0] sw_i_y,
  output logic [D_W-1:0] sw_i_data,
  input  logic           sw_i_ack,
  input  logic           sw_o_v,
  input  logic [X_W-1:0] sw_o_x,
  input  logic [Y_W-1:0] sw_o_y,
  input  logic [D_W-1:0] sw_o_data,
  output logic           rx_v,
  output logic [D_W-1:0] rx_data,
  output logic           err,
  output logic [15:0]    sent_cnt,
  output logic [15:0]    recv_cnt,
  output logic           idle
);

  msg_t tx_msg;
  msg_t head;
  logic full, empty;
  logic push_req, dest_ok, fifo_push;
  logic head_self, sw_pop, lb_pop, fifo_pop;
  logic rx_take, bad_dest, bad_deliver;

  assign tx_msg    = '{x: tx_x, y: tx_y, data: tx_data};
  assign tx_rdy    = !full;
  assign push_req  = tx_v && tx_rdy;
  assign dest_ok   = in_range(tx_x, tx_y, X, Y);
  assign fifo_push = push_req && dest_ok;

  // Offer depends only on FIFO state, keeping ack out of the sw_i_v cone.
  assign head_self = !empty && is_self(head.x, head.y, MY_X, MY_Y);
  assign sw_i_v    = !empty && !head_self;
  assign sw_pop    = sw_i_v && sw_i_ack;
  assign lb_pop    = head_self && !sw_o_v;
  assign fifo_pop  = sw_pop || lb_pop;

  assign sw_i_x    = head.x;
  assign sw_i_y    = head.y;
  assign sw_i_data = head.data;

  nic_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (tx_msg),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign rx_take     = sw_o_v || lb_pop;
  assign bad_dest    = push_req && !dest_ok;
  assign bad_deliver = sw_o_v && !is_self(sw_o_x, sw_o_y, MY_X, MY_Y);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_v     <= 1'b0;
      rx_data  <= '0;
      err      <= 1'b0;
      sent_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      rx_v <= rx_take;
      // Switch delivery wins; loopback only pops when sw_o_v is low.
      if (sw_o_v) begin
        rx_data <= sw_o_data;
      end else if (lb_pop) begin
        rx_data <= head.data;
      end
      if (rx_take) begin
        recv_cnt <= recv_cnt + 16'd1;
      end
      if (fifo_pop) begin
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (bad_dest || bad_deliver) begin
        err <= 1'b1;
      end
    end
  end

  assign idle = empty && !rx_v && !sw_o_v;

endmodule

// File: tb/tb_torus_nic.sv
// tb/tb_torus_nic.sv - directed table, hand sequences and random model check of torus_nic
module tb_torus_nic;

  localparam int NX = 2, NY = 2, MYX = 0, MYY = 0, DEP = 4;

  typedef struct {
    logic        tv;
    logic [1:0]  tx, ty;
    logic [31:0] td;
    logic        ack, ov;
    logic [1:0]  ox, oy;
    logic [31:0] od;
    logic        e_rdy, e_iv;
    logic [31:0] e_idata;
    logic        e_rxv;
    logic [31:0] e_rxd;
    logic [15:0] e_sent, e_recv;
    logic        e_err, e_idle;
  } vec_t;

  typedef struct {
    logic [1:0]  x, y;
    logic [31:0] data;
  } mmsg_t;

  logic clk = 1'b0;
  logic rst;
  logic tx_v, tx_rdy, sw_i_v, sw_i_ack, sw_o_v, rx_v, err, idle;
  logic [1:0] tx_x, tx_y, sw_i_x, sw_i_y, sw_o_x, sw_o_y;
  logic [31:0] tx_data, sw_i_data, sw_o_data, rx_data;
  logic [15:0] sent_cnt, recv_cnt;

  int checks = 0;
  int failures = 0;

  mmsg_t       mq[$];
  logic        m_rxv, m_err;
  logic [31:0] m_rxd;
  logic [15:0] m_sent, m_recv;

  torus_nic #(.X_W(2), .Y_W(2), .D_W(32), .X(NX), .Y(NY), .MY_X(MYX), .MY_Y(MYY), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .tx_v(tx_v), .tx_x(tx_x), .tx_y(tx_y), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .sw_i_v(sw_i_v), .sw_i_x(sw_i_x), .sw_i_y(sw_i_y), .sw_i_data(sw_i_data), .sw_i_ack(sw_i_ack),
    .sw_o_v(sw_o_v), .sw_o_x(sw_o_x), .sw_o_y(sw_o_y), .sw_o_data(sw_o_data),
    .rx_v(rx_v), .rx_data(rx_data), .err(err), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t row(input logic tv, input logic [1:0] tx, input logic [1:0] ty,
                               input logic [31:0] td, input logic ack, input logic ov,
                               input logic [1:0] ox, input logic [1:0] oy, input logic [31:0] od,
                               input logic e_rdy, input logic e_iv, input logic [31:0] e_idata,
                               input logic e_rxv, input logic [31:0] e_rxd, input logic [15:0] e_sent,
                               input logic [15:0] e_recv, input logic e_err, input logic e_idle);
    vec_t r;
    r.tv = tv; r.tx = tx; r.ty = ty; r.td = td; r.ack = ack; r.ov = ov;
    r.ox = ox; r.oy = oy; r.od = od; r.e_rdy = e_rdy; r.e_iv = e_iv; r.e_idata = e_idata;
    r.e_rxv = e_rxv; r.e_rxd = e_rxd; r.e_sent = e_sent; r.e_recv = e_recv;
    r.e_err = e_err; r.e_idle = e_idle;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rxv = 1'b0; m_rxd = '0; m_err = 1'b0; m_sent = '0; m_recv = '0;
  endtask

  // Drive one cycle, compare outputs with the model (and table row if given), then advance.
  task automatic cycle(input vec_t v, input bit tab);
    int          sz;
    logic        hs, e_iv, e_rdy, pop_sw, pop_lb;
    mmsg_t       h;
    tx_v = v.tv; tx_x = v.tx; tx_y = v.ty; tx_data = v.td; sw_i_ack = v.ack;
    sw_o_v = v.ov; sw_o_x = v.ox; sw_o_y = v.oy; sw_o_data = v.od;
    #1;
    sz = mq.size();
    h.x = '0; h.y = '0; h.data = '0;
    if (sz > 0) h = mq[0];
    hs    = (sz > 0) && (int'(h.x) == MYX) && (int'(h.y) == MYY);
    e_iv  = (sz > 0) && !hs;
    e_rdy = (sz < DEP);
    chk("mdl_tx_rdy", 32'(tx_rdy), 32'(e_rdy));
    chk("mdl_sw_i_v", 32'(sw_i_v), 32'(e_iv));
    chk("mdl_sw_i_xy", {28'd0, sw_i_x, sw_i_y}, {28'd0, h.x, h.y});
    chk("mdl_sw_i_data", sw_i_data, h.data);
    chk("mdl_rx_v", 32'(rx_v), 32'(m_rxv));
    chk("mdl_rx_data", rx_data, m_rxd);
    chk("mdl_counts", {sent_cnt, recv_cnt}, {m_sent, m_recv});
    chk("mdl_err", 32'(err), 32'(m_err));
    chk("mdl_idle", 32'(idle), 32'((sz == 0) && !m_rxv && !v.ov));
    if (tab) begin
      chk("tab_tx_rdy", 32'(tx_rdy), 32'(v.e_rdy));
      chk("tab_sw_i_v", 32'(sw_i_v), 32'(v.e_iv));
      chk("tab_sw_i_data", sw_i_data, v.e_idata);
      chk("tab_rx_v", 32'(rx_v), 32'(v.e_rxv));
      chk("tab_rx_data", rx_data, v.e_rxd);
      chk("tab_sent_cnt", 32'(sent_cnt), 32'(v.e_sent));
      chk("tab_recv_cnt", 32'(recv_cnt), 32'(v.e_recv));
      chk("tab_err", 32'(err), 32'(v.e_err));
      chk("tab_idle", 32'(idle), 32'(v.e_idle));
    end
    pop_sw = e_iv && v.ack;
    pop_lb = hs && !v.ov;
    if (v.ov) m_rxd = v.od;
    else if (pop_lb) m_rxd = h.data;
    m_rxv = v.ov || pop_lb;
    if (m_rxv) m_recv = m_recv + 16'd1;
    if (pop_sw || pop_lb) begin
      void'(mq.pop_front());
      m_sent = m_sent + 16'd1;
    end
    if (v.tv && e_rdy) begin
      if (int'(v.tx) < NX && int'(v.ty) < NY) mq.push_back('{x: v.tx, y: v.ty, data: v.td});
      else m_err = 1'b1;
    end
    if (v.ov && (int'(v.ox) != MYX || int'(v.oy) != MYY)) m_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t in_only(input logic tv, input logic [1:0] tx, input logic [1:0] ty,
                                   input logic [31:0] td, input logic ack, input logic ov,
                                   input logic [1:0] ox, input logic [1:0] oy, input logic [31:0] od);
    return row(tv, tx, ty, td, ack, ov, ox, oy, od, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t tab[15];
  vec_t v;

  initial begin
    rst = 1'b1;
    tx_v = 0; tx_x = 0; tx_y = 0; tx_data = 0; sw_i_ack = 0;
    sw_o_v = 0; sw_o_x = 0; sw_o_y = 0; sw_o_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //            tv tx ty td            ack ov ox oy od           rdy iv idata         rxv rxd           snt rcv er idl
    tab[0]  = row(0, 0, 0, 0,            0,  0, 0, 0, 0,           1,  0, 0,            0,  0,            0,  0,  0, 1);
    tab[1]  = row(1, 1, 1, 32'hDEADBEEF, 1,  0, 0, 0, 0,           1,  0, 0,            0,  0,            0,  0,  0, 1);
    tab[2]  = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  1, 32'hDEADBEEF, 0,  0,            0,  0,  0, 0);
    tab[3]  = row(0, 0, 0, 0,            0,  0, 0, 0, 0,           1,  0, 0,            0,  0,            1,  0,  0, 1);
    tab[4]  = row(0, 0, 0, 0,            0,  1, 0, 0, 32'h12345678, 1, 0, 0,            0,  0,            1,  0,  0, 0);
    tab[5]  = row(0, 0, 0, 0,            0,  0, 0, 0, 0,           1,  0, 0,            1,  32'h12345678, 1,  1,  0, 0);
    tab[6]  = row(1, 0, 0, 32'hA5,       0,  1, 0, 0, 32'h11,      1,  0, 0,            0,  32'h12345678, 1,  1,  0, 0);
    tab[7]  = row(0, 0, 0, 0,            1,  1, 0, 0, 32'h22,      1,  0, 32'hA5,       1,  32'h11,       1,  2,  0, 0);
    tab[8]  = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  0, 32'hA5,       1,  32'h22,       1,  3,  0, 0);
    tab[9]  = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  0, 0,            1,  32'hA5,       2,  4,  0, 0);
    tab[10] = row(1, 2, 0, 32'h77,       1,  0, 0, 0, 0,           1,  0, 0,            0,  32'hA5,       2,  4,  0, 1);
    tab[11] = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  0, 0,            0,  32'hA5,       2,  4,  1, 1);
    tab[12] = row(0, 0, 0, 0,            1,  1, 1, 0, 32'h99,      1,  0, 0,            0,  32'hA5,       2,  4,  1, 0);
    tab[13] = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  0, 0,            1,  32'h99,       2,  5,  1, 0);
    tab[14] = row(0, 0, 0, 0,            1,  0, 0, 0, 0,           1,  0, 0,            0,  32'h99,       2,  5,  1, 1);
    for (int i = 0; i < 15; i++) cycle(tab[i], 1'b1);

    // Backpressure: fill with ack low, fifth request waits, full blocks push even with a pop.
    for (int i = 0; i < 5; i++) cycle(in_only(1, 1, 0, 32'(i + 1), 0, 0, 0, 0, 0), 1'b0);
    chk("bp_full_rdy", 32'(tx_rdy), 32'd0);
    chk("bp_head_stable", sw_i_data, 32'd1);
    cycle(in_only(1, 1, 0, 32'd5, 1, 0, 0, 0, 0), 1'b0);
    chk("bp_after_pop_head", sw_i_data, 32'd2);
    cycle(in_only(1, 1, 0, 32'd5, 1, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 5; i++) cycle(in_only(0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    chk("bp_sent_total", 32'(sent_cnt), 32'd7);
    chk("bp_rdy_back", 32'(tx_rdy), 32'd1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v = in_only(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 7) == 0) ? 2'd1 : 2'd0, 2'd0, $urandom);
      cycle(v, 1'b0);
    end

    // Reset with traffic queued discards everything.
    for (int i = 0; i < 3; i++) cycle(in_only(1, 1, 1, 32'(16 + i), 0, 0, 0, 0, 0), 1'b0);
    tx_v = 0; sw_o_v = 0; sw_i_ack = 1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_sw_i_v", 32'(sw_i_v), 32'd0);
    chk("rst_sw_i_data", sw_i_data, 32'd0);
    chk("rst_tx_rdy", 32'(tx_rdy), 32'd1);
    chk("rst_counts", {sent_cnt, recv_cnt}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_rx", {31'd0, rx_v} | rx_data, 32'd0);
    for (int i = 0; i < 4; i++) cycle(in_only(0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
